// File: rtl/imm_gen_pkg.sv
// Shared opcodes and format codes for the pipelined immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_R   = 3'd5,
        FMT_ILL = 3'd6
    } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate extractor: instruction word to
// sign-extended immediate, format code and illegal-opcode flag.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [31:0] imm32;

    always_comb begin
        fmt = FMT_ILL;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:                                                  fmt = FMT_S;
            OPC_BRANCH:                                                 fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                                         fmt = FMT_U;
            OPC_JAL:                                                    fmt = FMT_J;
            OPC_OP, OPC_OP_32:                                          fmt = FMT_R;
            default:                                                    fmt = FMT_ILL;
        endcase
    end

    // Every format is assembled to 32 bits already sign-extended, then widened.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm     = XLEN'($signed(imm32));
    assign illegal = (fmt == FMT_ILL);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator behind a valid/ready skid buffer.
// Optional illegal-opcode counter enabled by defining IMM_GEN_STATS_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic             out_illegal
`ifdef IMM_GEN_STATS_EN
    ,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : gen_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (CNT_W < 1) begin : gen_bad_cnt_w
        $error("imm_gen_pipe: CNT_W must be at least 1");
    end

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr  (in_instr),
        .imm    (dec_imm),
        .fmt    (dec_fmt),
        .illegal(dec_illegal)
    );

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    imm_fmt_e        out_fmt_q, out_fmt_d;
    logic            out_illegal_q, out_illegal_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    imm_fmt_e        skid_fmt_q, skid_fmt_d;
    logic            skid_illegal_q, skid_illegal_d;

    logic accept;
    logic drain;

    // Ready depends only on registered state so out_ready never reaches in_ready.
    assign in_ready = !skid_valid_q && !reset;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_fmt_d      = out_fmt_q;
        out_illegal_d  = out_illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_fmt_d     = skid_fmt_q;
        skid_illegal_d = skid_illegal_q;

        if (!out_valid_q || drain) begin
            // Output slot frees up: skid has priority, else take the new entry.
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_imm_d     = skid_imm_q;
                out_fmt_d     = skid_fmt_q;
                out_illegal_d = skid_illegal_q;
                skid_valid_d  = 1'b0;
            end else if (accept) begin
                out_valid_d   = 1'b1;
                out_imm_d     = dec_imm;
                out_fmt_d     = dec_fmt;
                out_illegal_d = dec_illegal;
            end else begin
                out_valid_d   = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d   = 1'b1;
            skid_imm_d     = dec_imm;
            skid_fmt_d     = dec_fmt;
            skid_illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_fmt_q      <= FMT_R;
            out_illegal_q  <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_fmt_q     <= FMT_R;
            skid_illegal_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_fmt_q      <= out_fmt_d;
            out_illegal_q  <= out_illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_fmt_q     <= skid_fmt_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_illegal_q;

`ifdef IMM_GEN_STATS_EN
    logic [CNT_W-1:0] illegal_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt_q <= '0;
        end else if (drain && out_illegal_q && (illegal_cnt_q != '1)) begin
            illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
        end
    end

    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (XLEN=64, CNT_W=2): decode, skid buffer,
// reset and, when IMM_GEN_STATS_EN is defined, the saturating counter.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 2;

    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_SD   = 32'h00113423;
    localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
    localparam logic [31:0] I_LUI  = 32'h800000B7;
    localparam logic [31:0] I_JAL  = 32'h0010006F;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    imm_fmt_e         out_fmt;
    logic             out_illegal;
`ifdef IMM_GEN_STATS_EN
    logic [CNT_W-1:0] illegal_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(
        .XLEN (XLEN),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal)
`ifdef IMM_GEN_STATS_EN
        ,
        .illegal_cnt(illegal_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [63:0] imm, input imm_fmt_e fmt,
                             input logic ill);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".imm"}, out_imm, imm);
        check({tag, ".fmt"}, 64'(out_fmt), 64'(fmt));
        check({tag, ".ill"}, 64'(out_illegal), 64'(ill));
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst.in_ready", 64'(in_ready), 64'd0);
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.imm", out_imm, 64'd0);
        check("rst.fmt", 64'(out_fmt), 64'(FMT_R));
        check("rst.ill", 64'(out_illegal), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst.in_ready", 64'(in_ready), 64'd1);

        // Single-issue decode, one result per cycle.
        in_valid = 1'b1;
        in_instr = I_ADDI; tick(); check_out("addi", 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
        in_instr = I_SD;   tick(); check_out("sd",   64'h8, FMT_S, 1'b0);
        in_instr = I_BEQ;  tick(); check_out("beq",  64'hFFFFFFFFFFFFFFFC, FMT_B, 1'b0);
        in_instr = I_LUI;  tick(); check_out("lui",  64'hFFFFFFFF80000000, FMT_U, 1'b0);
        in_instr = I_JAL;  tick(); check_out("jal",  64'h800, FMT_J, 1'b0);
        in_instr = I_ADD;  tick(); check_out("add",  64'h0, FMT_R, 1'b0);
        in_valid = 1'b0;
        in_instr = I_LUI;
        tick();
        check("idle.valid", 64'(out_valid), 64'd0);

        // Backpressure: fill out and skid, third instruction held upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_ADDI; tick();
        check_out("bp.addi", 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
        check("bp.ready1", 64'(in_ready), 64'd1);
        in_instr = I_SD; tick();
        check("bp.ready2", 64'(in_ready), 64'd0);
        check_out("bp.hold1", 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
        in_instr = I_BEQ; tick();
        check_out("bp.hold2", 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
        check("bp.ready3", 64'(in_ready), 64'd0);
        out_ready = 1'b1; tick();
        check_out("bp.sd", 64'h8, FMT_S, 1'b0);
        check("bp.ready4", 64'(in_ready), 64'd1);
        tick();
        check_out("bp.beq", 64'hFFFFFFFFFFFFFFFC, FMT_B, 1'b0);
        in_valid = 1'b0; tick();
        check("bp.empty", 64'(out_valid), 64'd0);

        // Illegal opcodes drain freely; counter must saturate at 3.
        in_valid = 1'b1;
        in_instr = I_BAD;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("ill", 64'h0, FMT_ILL, 1'b1);
        end
        in_valid = 1'b0; tick();
        check("ill.empty", 64'(out_valid), 64'd0);
`ifdef IMM_GEN_STATS_EN
        check("cnt.sat", 64'(illegal_cnt), 64'd3);
`endif

        // Stall with both entries full, then reset mid-operation.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick(); tick();
        check("stall.ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("mid_rst.in_ready", 64'(in_ready), 64'd0);
        tick();
        check("mid_rst.valid", 64'(out_valid), 64'd0);
        check("mid_rst.imm", out_imm, 64'd0);
        check("mid_rst.fmt", 64'(out_fmt), 64'(FMT_R));
        check("mid_rst.ill", 64'(out_illegal), 64'd0);
`ifdef IMM_GEN_STATS_EN
        check("mid_rst.cnt", 64'(illegal_cnt), 64'd0);
`endif
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("after_rst.in_ready", 64'(in_ready), 64'd1);
        tick();
        check("after_rst.valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate extractor used in the single-cycle core.
- Decodes all RV32I/RV64I immediate formats: I, S, B, U, J, plus R (no immediate).
- Sign-extends the immediate to XLEN.
- Registers the result behind a valid/ready interface with a 2-entry skid buffer, so it can sit between the fetch and decode stages of the pipelined core.

Parameters:
XLEN, 64, output immediate width; legal values 32 or 64 (elaboration error otherwise).
CNT_W, 16, width of the illegal-opcode counter (used only with the optional feature).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous reset, active high.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  block can accept an instruction this cycle.
in_instr  in  32  raw instruction word.
out_valid  out  1  registered result valid.
out_ready  in  1  downstream accepts the result.
out_imm  out  XLEN  sign-extended immediate.
out_fmt  out  3  format code (imm_fmt_e).
out_illegal  out  1  opcode not recognised.
illegal_cnt  out  CNT_W  saturating illegal-opcode count (present only with IMM_GEN_STATS_EN).

Behaviour:
- Format decode from in_instr[6:0]:
  - I: 0000011, 0010011, 0011011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011, 0111011.
  - Anything else: ILLEGAL.
- Immediate assembly, each then sign-extended from its top bit to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, a 13-bit byte offset with bit0 = 0.
  - U = {instr[31:12], 12'b0}, 32 bits.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 21 bits.
  - R and ILLEGAL: out_imm = 0.
  - I-type shifts: the shamt/funct bits are emitted unmodified; masking is the consumer's job.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Skid buffer: a main output register plus one skid register.
  - in_ready = !skid_valid && !reset, a pure function of registered state (no combinational path from out_ready).
  - Latency: a transfer accepted in cycle N appears on out_* in cycle N+1 when the output register is empty or draining.
  - Accepted transfer while the output stalls (out_valid && !out_ready): the entry goes to skid; in_ready drops the next cycle.
  - When out drains with skid full: skid moves to out; skid empties; in_ready rises the next cycle.
  - Simultaneous input accept and output drain with skid empty: the new entry loads directly into out (full throughput, one result per cycle).
  - Order is strictly FIFO; no drop or duplication.
- Stability: out_imm, out_fmt and out_illegal must hold stable while out_valid && !out_ready.
- Reset, including mid-operation: next edge gives out_valid = 0, skid_valid = 0, out_imm = 0, out_fmt = FMT_R, out_illegal = 0. In-flight entries are discarded; in_ready = 0 while reset is high.
- Inputs are ignored when in_valid = 0; registers hold.

Optional Feature:
IMM_GEN_STATS_EN.
- Defined: illegal_cnt port exists. It increments by 1 on every output transfer with out_illegal = 1, saturates at all-ones (no wrap), and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package imm_gen_pkg:
  - opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP_32);
  - enum imm_fmt_e (FMT_I = 0, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_ILL).
- Sub-module imm_decode: purely combinational, instr → {imm, fmt, illegal}, parametrised on XLEN.
- The top level holds the skid buffer and the optional counter.

Test Plan:
1. XLEN=64, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=FMT_I, out_illegal=0.
2. 0x00113423 (sd x1,8(x2)) → out_imm=8, FMT_S.
3. 0xFE000EE3 (beq x0,x0,-4) → out_imm=0xFFFFFFFFFFFFFFFC, FMT_B.
4. Single instructions, each with out_ready=1:
   - 0x800000B7 (lui) → 0xFFFFFFFF80000000, FMT_U; with XLEN=32 → 0x80000000.
   - 0x0010006F (jal x0,0x800) → 0x800, FMT_J.
5. Backpressure: out_ready=0, push addi, sd, beq back-to-back.
   - in_ready drops after the 2nd accept; the 3rd is held upstream.
   - Raise out_ready: results emerge addi, sd, beq in order, one per cycle, outputs stable while stalled.
6. 0x0000007F pushed 3 times, then reset asserted mid-stall:
   - each emerges as out_illegal=1, out_imm=0, FMT_ILL;
   - with IMM_GEN_STATS_EN and CNT_W=2: illegal_cnt saturates at 3 (no wrap);
   - reset → out_valid=0, illegal_cnt=0, in_ready=1 the cycle after reset deasserts.
